// File: rtl/ofdm_tx_pkg.sv
// rtl/ofdm_tx_pkg.sv - shared state encoding, defaults and counter sizing for the OFDM TX scheduler
package ofdm_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DATA = 2'd3
   } sched_state_e;

   localparam int SYM_LEN_DEF = 192;
   localparam int GAP_CYC_DEF = 2;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ofdm_sched_ostage.sv
// rtl/ofdm_sched_ostage.sv - registered master output stage; holds word and strobe until acknowledged
module ofdm_sched_ostage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   output logic [31:0] dat_o,
   output logic        stb_o
);

   logic [31:0] dat_q, dat_d;
   logic        stb_q, stb_d;

   always_comb begin
      dat_d = dat_q;
      stb_d = stb_q;
      if (load_i) begin
         dat_d = dat_i;
         stb_d = 1'b1;
      end else if (ack_i) begin
         stb_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dat_q <= 32'd0;
         stb_q <= 1'b0;
      end else begin
         dat_q <= dat_d;
         stb_q <= stb_d;
      end
   end

   assign dat_o = dat_q;
   assign stb_o = stb_q;

endmodule

// File: rtl/ofdm_sym_sched.sv
// rtl/ofdm_sym_sched.sv - OFDM frame scheduler: preamble symbol, then FRM_NSYM data symbols separated by gaps.
// Optional OFDM_SCHED_UNDERRUN_EN adds the UNDERRUN_CNT data-starvation counter.
module ofdm_sym_sched
   import ofdm_tx_pkg::*;
#(
   parameter int SYM_LEN = SYM_LEN_DEF,
   parameter int GAP_CYC = GAP_CYC_DEF
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] P_DAT_I,
   input  logic        P_CYC_I,
   input  logic        P_STB_I,
   input  logic        P_WE_I,
   output logic        P_ACK_O,
   input  logic [31:0] D_DAT_I,
   input  logic        D_CYC_I,
   input  logic        D_STB_I,
   input  logic        D_WE_I,
   output logic        D_ACK_O,
   output logic [31:0] DAT_O,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I,
`ifdef OFDM_SCHED_UNDERRUN_EN
   output logic [15:0] UNDERRUN_CNT,
`endif
   input  logic [7:0]  FRM_NSYM,
   input  logic        FRM_START,
   output logic        BUSY,
   output logic        FRM_DONE
);

   localparam int          CW       = cnt_w(SYM_LEN);
   localparam logic [CW:0] LEN_W    = (CW + 1)'(SYM_LEN);
   localparam logic [CW-1:0] LAST_W = CW'(SYM_LEN - 1);
   localparam logic [3:0]  GAP_LAST = 4'(GAP_CYC - 1);

   sched_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    gap_q, gap_d;
   logic [7:0]    nsym_q, nsym_d;
   logic          cyc_q, cyc_d;
   logic          done_q, done_d;

   logic sel_p, sel_d, ready, room, load, xfer, sym_end;
   logic [31:0] src_dat;

   assign sel_p   = (state_q == ST_PRE);
   assign sel_d   = (state_q == ST_DATA);
   assign ready   = ~STB_O | ACK_I;
   // The word sitting in the output stage already counts against the symbol length.
   assign room    = ({1'b0, cnt_q} + {{CW{1'b0}}, STB_O}) < LEN_W;
   assign P_ACK_O = sel_p & P_CYC_I & P_STB_I & P_WE_I & ready & room;
   assign D_ACK_O = sel_d & D_CYC_I & D_STB_I & D_WE_I & ready & room;
   assign load    = P_ACK_O | D_ACK_O;
   assign src_dat = sel_d ? D_DAT_I : P_DAT_I;
   assign xfer    = STB_O & ACK_I;
   assign sym_end = xfer & (cnt_q == LAST_W);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      nsym_d  = nsym_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (FRM_START) begin
               state_d = ST_PRE;
               nsym_d  = FRM_NSYM;
               cnt_d   = '0;
            end
         end
         ST_PRE, ST_DATA: begin
            if (xfer) cnt_d = cnt_q + CW'(1);
            if (sym_end) begin
               cnt_d   = '0;
               gap_d   = 4'd0;
               state_d = ST_GAP;
               if (state_q == ST_DATA) nsym_d = nsym_q - 8'd1;
            end
         end
         ST_GAP: begin
            gap_d = gap_q + 4'd1;
            if (gap_q == GAP_LAST) begin
               gap_d = 4'd0;
               if (nsym_q != 8'd0) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // CYC_O rises the cycle after a symbol state is entered and drops on its last transfer.
      cyc_d = ((state_d == ST_PRE) || (state_d == ST_DATA)) && (state_d == state_q);
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         gap_q   <= 4'd0;
         nsym_q  <= 8'd0;
         cyc_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         nsym_q  <= nsym_d;
         cyc_q   <= cyc_d;
         done_q  <= done_d;
      end
   end

   ofdm_sched_ostage u_ostage (
      .clk_i  (CLK_I),
      .rst_i  (RST_I),
      .load_i (load),
      .dat_i  (src_dat),
      .ack_i  (ACK_I),
      .dat_o  (DAT_O),
      .stb_o  (STB_O)
   );

   assign WE_O     = STB_O;
   assign CYC_O    = cyc_q;
   assign BUSY     = (state_q != ST_IDLE);
   assign FRM_DONE = done_q;

`ifdef OFDM_SCHED_UNDERRUN_EN
   logic [15:0] urun_q, urun_d;

   always_comb begin
      urun_d = urun_q;
      if (sel_d && ready && !D_STB_I && (urun_q != 16'hFFFF)) urun_d = urun_q + 16'd1;
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) urun_q <= 16'd0;
      else       urun_q <= urun_d;
   end

   assign UNDERRUN_CNT = urun_q;
`endif

endmodule

// File: tb/tb_ofdm_sym_sched.sv
// tb/tb_ofdm_sym_sched.sv - self-checking bench for ofdm_sym_sched against a word-order/frame-shape model
module tb_ofdm_sym_sched;

   localparam int SYM_LEN = 192;
   localparam int GAP_CYC = 2;
   localparam int MEM_N   = 8192;
   localparam int BUDGET  = 20000;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic [31:0] P_DAT_I, D_DAT_I, DAT_O;
   logic        P_CYC_I, P_STB_I, P_WE_I, P_ACK_O;
   logic        D_CYC_I, D_STB_I, D_WE_I, D_ACK_O;
   logic        CYC_O, STB_O, WE_O, ACK_I;
   logic [7:0]  FRM_NSYM;
   logic        FRM_START, BUSY, FRM_DONE;
`ifdef OFDM_SCHED_UNDERRUN_EN
   logic [15:0] UNDERRUN_CNT;
`endif

   ofdm_sym_sched #(.SYM_LEN(SYM_LEN), .GAP_CYC(GAP_CYC)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .P_DAT_I(P_DAT_I), .P_CYC_I(P_CYC_I), .P_STB_I(P_STB_I), .P_WE_I(P_WE_I), .P_ACK_O(P_ACK_O),
      .D_DAT_I(D_DAT_I), .D_CYC_I(D_CYC_I), .D_STB_I(D_STB_I), .D_WE_I(D_WE_I), .D_ACK_O(D_ACK_O),
      .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
`ifdef OFDM_SCHED_UNDERRUN_EN
      .UNDERRUN_CNT(UNDERRUN_CNT),
`endif
      .FRM_NSYM(FRM_NSYM), .FRM_START(FRM_START), .BUSY(BUSY), .FRM_DONE(FRM_DONE)
   );

   always #5 CLK_I = ~CLK_I;

   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] pmem [MEM_N];
   logic [31:0] dmem [MEM_N];
   int p_idx = 0, d_idx = 0, p0 = 0, d0 = 0;
   logic [31:0] got [$];
   int len_q [$];
   int gap_q [$];
   int rises, low_run, sym_words, done_cnt, d_ack_cnt, prot_err;
   logic cyc_prev, stall_prev, s_cyc, s_stb;
   logic [31:0] dat_prev;
   bit rnd_mode = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: observe at the falling edge, advance the source models just after the rising edge.
   task automatic tick();
      logic p_take, d_take;
      @(negedge CLK_I);
      s_cyc = CYC_O;
      s_stb = STB_O;
      if (WE_O !== STB_O) prot_err++;
      if (STB_O && !CYC_O) prot_err++;
      if (P_ACK_O && D_ACK_O) prot_err++;
      if (stall_prev && (!STB_O || DAT_O !== dat_prev)) prot_err++;
      stall_prev = STB_O && !ACK_I;
      dat_prev   = DAT_O;
      if (STB_O && ACK_I) begin
         got.push_back(DAT_O);
         sym_words++;
      end
      if (!CYC_O) low_run++;
      if (CYC_O && !cyc_prev) begin
         if (rises > 0) gap_q.push_back(low_run);
         rises++;
         low_run = 0;
      end
      if (!CYC_O && cyc_prev) begin
         len_q.push_back(sym_words);
         sym_words = 0;
      end
      cyc_prev = CYC_O;
      if (FRM_DONE) done_cnt++;
      if (D_ACK_O) d_ack_cnt++;
      p_take = P_ACK_O;
      d_take = D_ACK_O;
      @(posedge CLK_I);
      #1;
      if (p_take) p_idx++;
      if (d_take) d_idx++;
      P_DAT_I = pmem[p_idx];
      D_DAT_I = dmem[d_idx];
      if (rnd_mode) begin
         ACK_I   = ($urandom_range(0, 3) != 0);
         P_STB_I = ($urandom_range(0, 3) != 0);
         D_STB_I = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic start_frame(input int nsym);
      got.delete();
      len_q.delete();
      gap_q.delete();
      rises = 0; low_run = 0; sym_words = 0; done_cnt = 0; d_ack_cnt = 0; prot_err = 0;
      cyc_prev = 1'b0; stall_prev = 1'b0;
      p0 = p_idx;
      d0 = d_idx;
      FRM_NSYM  = 8'(nsym);
      FRM_START = 1'b1;
      tick();
      FRM_START = 1'b0;
   endtask

   task automatic wait_words(input string tag, input int n);
      int k = 0;
      while (got.size() < n && k < BUDGET) begin
         tick();
         k++;
      end
      check({tag, ".reach_word"}, 64'(got.size() >= n), 64'd1);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done_cnt == 0 && k < BUDGET) begin
         tick();
         k++;
      end
      check({tag, ".done_seen"}, 64'(done_cnt > 0), 64'd1);
      for (int i = 0; i < 4; i++) tick();
   endtask

   // Expected stream: SYM_LEN preamble words, then nsym*SYM_LEN data words, each in source order.
   task automatic check_frame(input string t, input int nsym);
      int nexp = SYM_LEN * (nsym + 1);
      int mism = 0;
      check({t, ".nwords"}, 64'(got.size()), 64'(nexp));
      for (int i = 0; i < got.size() && i < nexp; i++) begin
         logic [31:0] e;
         e = (i < SYM_LEN) ? pmem[p0 + i] : dmem[d0 + i - SYM_LEN];
         if (got[i] !== e) mism++;
      end
      check({t, ".data"}, 64'(mism), 64'd0);
      check({t, ".p_used"}, 64'(p_idx - p0), 64'(SYM_LEN));
      check({t, ".d_used"}, 64'(d_idx - d0), 64'(SYM_LEN * nsym));
      check({t, ".cyc_rises"}, 64'(rises), 64'(nsym + 1));
      check({t, ".nsyms"}, 64'(len_q.size()), 64'(nsym + 1));
      foreach (len_q[i]) check({t, ".sym_len"}, 64'(len_q[i]), 64'(SYM_LEN));
      check({t, ".ngaps"}, 64'(gap_q.size()), 64'(nsym));
      foreach (gap_q[i]) check({t, ".gap_len"}, 64'(gap_q[i]), 64'(GAP_CYC + 1));
      check({t, ".done_cnt"}, 64'(done_cnt), 64'd1);
      check({t, ".protocol"}, 64'(prot_err), 64'd0);
      check({t, ".busy_end"}, 64'(BUSY), 64'd0);
   endtask

   initial begin
      int cyc_lo, stb_hi, n;
      for (int i = 0; i < MEM_N; i++) begin
         pmem[i] = $urandom;
         dmem[i] = $urandom;
      end
      RST_I = 1'b1;
      P_DAT_I = pmem[0]; P_CYC_I = 1'b1; P_STB_I = 1'b1; P_WE_I = 1'b1;
      D_DAT_I = dmem[0]; D_CYC_I = 1'b1; D_STB_I = 1'b1; D_WE_I = 1'b1;
      ACK_I = 1'b1; FRM_NSYM = 8'd0; FRM_START = 1'b0;
      @(posedge CLK_I);
      #1;
      check("reset.outs", 64'({DAT_O, CYC_O, STB_O, WE_O, P_ACK_O, D_ACK_O, BUSY, FRM_DONE}), 64'd0);
      RST_I = 1'b0;
      tick();
      check("idle.busy", 64'(BUSY), 64'd0);

      // Test 1: two data symbols, full throughput.
      start_frame(2);
      check("t1.busy", 64'(BUSY), 64'd1);
      wait_done("t1");
      check_frame("t1", 2);

      // Test 2: preamble only.
      start_frame(0);
      wait_done("t2");
      check_frame("t2", 0);
      check("t2.d_ack", 64'(d_ack_cnt), 64'd0);

      // Test 3: master stall of 5 cycles after word 100.
      start_frame(1);
      wait_words("t3", 100);
      ACK_I = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      ACK_I = 1'b1;
      wait_done("t3");
      check_frame("t3", 1);

      // Test 4: data source starves for 10 cycles mid-symbol.
      start_frame(1);
      wait_words("t4", SYM_LEN + 60);
      D_STB_I = 1'b0;
      cyc_lo = 0;
      stb_hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!s_cyc) cyc_lo++;
         if (s_stb) stb_hi++;
      end
      D_STB_I = 1'b1;
      check("t4.cyc_low", 64'(cyc_lo), 64'd0);
      check("t4.stb_high", 64'(stb_hi), 64'd1);
      check("t4.stb_last", 64'(s_stb), 64'd0);
      wait_done("t4");
      check_frame("t4", 1);
`ifdef OFDM_SCHED_UNDERRUN_EN
      check("t4.underrun", 64'(UNDERRUN_CNT), 64'd10);
`endif

      // Test 5: asynchronous reset at data word 50 aborts the frame.
      start_frame(1);
      wait_words("t5", SYM_LEN + 50);
      #2;
      RST_I = 1'b1;
      #1;
      check("t5.rst_outs", 64'({DAT_O, CYC_O, STB_O, WE_O, P_ACK_O, D_ACK_O, BUSY, FRM_DONE}), 64'd0);
`ifdef OFDM_SCHED_UNDERRUN_EN
      check("t5.rst_underrun", 64'(UNDERRUN_CNT), 64'd0);
`endif
      tick();
      tick();
      RST_I = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("t5.no_done", 64'(done_cnt), 64'd0);
      start_frame(1);
      wait_done("t5b");
      check_frame("t5b", 1);

      // Test 6: FRM_START during DATA must not disturb the running frame.
      start_frame(2);
      wait_words("t6", SYM_LEN + 30);
      FRM_NSYM  = 8'd5;
      FRM_START = 1'b1;
      tick();
      FRM_START = 1'b0;
      wait_done("t6");
      check_frame("t6", 2);

      // Randomized handshakes on both sides.
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(0, 3);
         rnd_mode = 1;
         start_frame(n);
         wait_done("rnd");
         rnd_mode = 0;
         ACK_I = 1'b1; P_STB_I = 1'b1; D_STB_I = 1'b1;
         check_frame("rnd", n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ofdm_sym_sched.md
OFDM_SYM_SCHED -- requirements
Module: ofdm_sym_sched

Interface
REQ-001 SHALL have parameter SYM_LEN, default 192, meaning data words per OFDM symbol delivered downstream.
REQ-002 SHALL have parameter GAP_CYC, default 2, meaning idle cycles with CYC_O low between symbols; legal range 1..15.
REQ-003 SHALL have ports CLK_I in 1 (system clock) and RST_I in 1 (reset); reset is asynchronous and active-high.
REQ-004 SHALL have ports P_DAT_I in 32, P_CYC_I in 1, P_STB_I in 1, P_WE_I in 1 and P_ACK_O out 1, forming the preamble-source slave port.
REQ-005 SHALL have ports D_DAT_I in 32, D_CYC_I in 1, D_STB_I in 1, D_WE_I in 1 and D_ACK_O out 1, forming the data-mapper slave port.
REQ-006 SHALL have ports DAT_O out 32, CYC_O out 1, STB_O out 1, WE_O out 1 and ACK_I in 1, forming the master port toward the pilot inserter.
REQ-007 SHALL have ports FRM_NSYM in 8 (data symbols per frame, sampled at frame start) and FRM_START in 1 (one-cycle frame request pulse).
REQ-008 SHALL have ports BUSY out 1 (frame in progress) and FRM_DONE out 1 (one-cycle pulse at end of frame).

Function
REQ-009 SHALL implement states IDLE, PRE, GAP and DATA.
REQ-010 IDLE->PRE on FRM_START, latching FRM_NSYM; FRM_START when not IDLE SHALL be ignored.
REQ-011 PRE SHALL forward exactly SYM_LEN preamble words, then go to GAP.
REQ-012 GAP SHALL hold CYC_O=0 and STB_O=0 for GAP_CYC cycles; afterwards -> DATA if symbols remain, else -> IDLE with FRM_DONE=1 for one cycle.
REQ-013 DATA SHALL forward exactly SYM_LEN data-mapper words per symbol, decrement the remaining-symbol count, then go to GAP.
REQ-014 With FRM_NSYM=0 latched, the sequence SHALL be PRE, GAP, IDLE (preamble only).
REQ-015 CYC_O SHALL be 1 throughout each PRE/DATA symbol, including stalls, and SHALL rise one cycle after entering the state; every symbol therefore begins with a CYC_O rising edge.
REQ-016 The selected source ACK SHALL equal sel & x_CYC_I & x_STB_I & x_WE_I & (~STB_O | ACK_I) & (word count < SYM_LEN); the unselected ACK SHALL be 0.
REQ-017 DAT_O and STB_O SHALL be registered with one-cycle latency from an accepted word; while STB_O & ~ACK_I, DAT_O and STB_O SHALL hold.
REQ-018 WE_O SHALL equal STB_O.
REQ-019 The word counter SHALL count master-side transfers (STB_O & ACK_I), width ceil(log2(SYM_LEN+1)); the symbol SHALL end on the transfer that brings the count to SYM_LEN, with no wrap.
REQ-020 A source deasserting STB mid-symbol SHALL stall the symbol (STB_O drops and CYC_O stays high); the word count SHALL be unaffected.
REQ-021 BUSY SHALL be 1 in every state except IDLE.

Reset
REQ-022 On RST_I, state SHALL go to IDLE and all counters to 0.
REQ-023 On RST_I, the outputs DAT_O, CYC_O, STB_O, WE_O, P_ACK_O, D_ACK_O, BUSY and FRM_DONE SHALL all be 0.
REQ-024 Reset mid-symbol SHALL abort the frame immediately, with no FRM_DONE pulse.

Configuration
REQ-025 With OFDM_SCHED_UNDERRUN_EN defined, the block SHALL add output UNDERRUN_CNT (16 bits) that increments, saturating at 16'hFFFF, on each DATA-state cycle where the master is ready (~STB_O | ACK_I) and D_STB_I=0; it SHALL clear on RST_I.
REQ-026 With OFDM_SCHED_UNDERRUN_EN undefined, the UNDERRUN_CNT port and its logic SHALL be absent.

Structure
REQ-027 State encoding, SYM_LEN/GAP_CYC defaults and the counter-width function SHALL live in shared package ofdm_tx_pkg.
REQ-028 The registered output stage (REQ-017) SHALL be sub-module ofdm_sched_ostage; the rest of the design SHALL be flat.

Verification
REQ-029 Test 1: FRM_NSYM=2, both sources always valid, ACK_I=1 -> 192 preamble words, GAP 2 cycles, 192 data words, gap, 192 data words, gap, then FRM_DONE, with 3 CYC_O rising edges.
REQ-030 Test 2: FRM_NSYM=0 -> one 192-word preamble symbol, then FRM_DONE; D_ACK_O is never 1.
REQ-031 Test 3: ACK_I low for 5 cycles at word 100 -> DAT_O stable and no words lost or duplicated; the symbol still contains exactly 192 words.
REQ-032 Test 4: D_STB_I low for 10 cycles mid-symbol -> CYC_O stays 1 and STB_O goes 0; with the macro defined, UNDERRUN_CNT=10.
REQ-033 Test 5: RST_I asserted at data word 50 -> all outputs 0 asynchronously; a following FRM_START runs a full frame.
REQ-034 Test 6: FRM_START pulsed during DATA -> ignored; the frame length is unchanged.
